systolic_feeder: RTL

- Producer side of the systolic array's operand interface.
- Latches a pair of SIZE x SIZE signed matrices on a start handshake and clears the array's accumulators.
- Drives the diagonally skewed row stream (a_out) and column stream (b_out) the array consumes, zero-padding outside each diagonal.
- Waits for the array pipeline to drain, then pulses result_valid so the Strassen controller can sample the array's C outputs.

---
 rtl/systolic_pkg.sv | 43 ++++
 rtl/skew_lane_mux.sv | 48 ++++
 rtl/systolic_feeder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pkg
// Brief    : Shared types, defaults and skew helper for the systolic feeder
//            and the systolic array it drives.
// Revision : 1.0  initial release
// ============================================================================
package systolic_pkg;

  // Default geometry shared by the feeder and the array
  localparam int c_default_size       = 4;
  localparam int c_default_data_width = 10;

  // Feeder sequencing states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } feeder_state_t;

  // Result of a diagonal-skew lookup: whether the lane carries data at this
  // step, and which position along the lane's row/column it carries.
  typedef struct packed {
    logic        valid;
    logic [15:0] idx;
  } skew_sel_t;

  // On step k, lane `lane` carries element (k - lane) of its row/column
  // when that falls inside the matrix, otherwise it is zero-padded.
  function automatic skew_sel_t skew_sel(input int k, input int lane,
                                         input int size = c_default_size);
    skew_sel_t r;
    int        d;
    d       = k - lane;
    r.valid = (d >= 0) && (d < size);
    r.idx   = r.valid ? 16'(d) : 16'd0;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skew_lane_mux.sv
`default_nettype none
// ============================================================================
// Module   : skew_lane_mux
// Brief    : Selects one lane's diagonal element (or zero) of a flattened
//            SIZE x SIZE matrix for feed step k. TRANSPOSE=0 walks row LANE
//            (A stream); TRANSPOSE=1 walks column LANE (B stream).
// Revision : 1.0  initial release
// ============================================================================
module skew_lane_mux
  import systolic_pkg::*;
#(
  parameter int SIZE       = c_default_size,
  parameter int DATA_WIDTH = c_default_data_width,
  parameter int LANE       = 0,
  parameter bit TRANSPOSE  = 1'b0,
  parameter int CNT_W      = 4
) (
  input  logic [SIZE*SIZE*DATA_WIDTH-1:0] mat_i,
  input  logic [CNT_W-1:0]                k_i,
  output logic [DATA_WIDTH-1:0]           lane_o
);

  localparam int c_el_w = $clog2(SIZE*SIZE);

  // Element e of the flattened matrix is row e/SIZE, column e%SIZE
  logic [DATA_WIDTH-1:0] elem [SIZE*SIZE];

  for (genvar e = 0; e < SIZE*SIZE; e++) begin : g_elem
    assign elem[e] = mat_i[e*DATA_WIDTH +: DATA_WIDTH];
  end

  skew_sel_t sel_d;
  int        flat_d;

  // Map the skew position onto a flat element index and zero-pad outside
  always_comb begin
    sel_d  = skew_sel(int'(k_i), LANE, SIZE);
    flat_d = 0;
    if (TRANSPOSE) begin
      flat_d = int'(sel_d.idx) * SIZE + LANE;
    end else begin
      flat_d = LANE * SIZE + int'(sel_d.idx);
    end
    lane_o = sel_d.valid ? elem[c_el_w'(flat_d)] : '0;
  end

endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_feeder
// Brief    : Latches an A/B operand pair on start, clears the array, streams
//            the diagonally skewed rows of A and columns of B, waits for the
//            array pipeline to drain and pulses result_valid.
// Revision : 1.0  initial release
// ============================================================================
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int SIZE         = c_default_size,
  parameter int DATA_WIDTH   = c_default_data_width,
  parameter int DRAIN_CYCLES = SIZE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [SIZE*SIZE*DATA_WIDTH-1:0] mat_a,
  input  logic [SIZE*SIZE*DATA_WIDTH-1:0] mat_b,
  output logic                           busy,
  output logic                           array_rst,
  output logic                           feed_valid,
  output logic [SIZE*DATA_WIDTH-1:0]     a_out,
  output logic [SIZE*DATA_WIDTH-1:0]     b_out,
  output logic                           result_valid
);

  localparam int c_cnt_w = $clog2(2*SIZE-1 + DRAIN_CYCLES) + 1;
  localparam logic [c_cnt_w-1:0] c_feed_last  = c_cnt_w'(2*SIZE-2);
  localparam logic [c_cnt_w-1:0] c_drain_last = c_cnt_w'(DRAIN_CYCLES-1);

  feeder_state_t                    state_q;
  logic [c_cnt_w-1:0]               cnt_q;
  logic [SIZE*SIZE*DATA_WIDTH-1:0]  mat_a_q;
  logic [SIZE*SIZE*DATA_WIDTH-1:0]  mat_b_q;
  logic                             busy_q;
  logic                             feed_valid_q;
  logic                             result_valid_q;
  logic [SIZE*DATA_WIDTH-1:0]       a_out_q;
  logic [SIZE*DATA_WIDTH-1:0]       b_out_q;

  // Outputs are registered, so the lane muxes look one step ahead
  logic [c_cnt_w-1:0]               k_d;
  logic [SIZE*DATA_WIDTH-1:0]       a_next_d;
  logic [SIZE*DATA_WIDTH-1:0]       b_next_d;

  // Feed step the lanes will present in the next cycle
  always_comb begin
    k_d = '0;
    if (state_q == FEED) begin
      k_d = cnt_q + c_cnt_w'(1);
    end
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    skew_lane_mux #(
      .SIZE       (SIZE),
      .DATA_WIDTH (DATA_WIDTH),
      .LANE       (i),
      .TRANSPOSE  (1'b0),
      .CNT_W      (c_cnt_w)
    ) u_a_mux (
      .mat_i  (mat_a_q),
      .k_i    (k_d),
      .lane_o (a_next_d[i*DATA_WIDTH +: DATA_WIDTH])
    );

    skew_lane_mux #(
      .SIZE       (SIZE),
      .DATA_WIDTH (DATA_WIDTH),
      .LANE       (i),
      .TRANSPOSE  (1'b1),
      .CNT_W      (c_cnt_w)
    ) u_b_mux (
      .mat_i  (mat_b_q),
      .k_i    (k_d),
      .lane_o (b_next_d[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Sequencer: state, step counter, operand latches and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mat_a_q        <= '0;
      mat_b_q        <= '0;
      busy_q         <= 1'b0;
      feed_valid_q   <= 1'b0;
      result_valid_q <= 1'b0;
      a_out_q        <= '0;
      b_out_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mat_a_q <= mat_a;
            mat_b_q <= mat_b;
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          state_q      <= FEED;
          cnt_q        <= '0;
          feed_valid_q <= 1'b1;
          a_out_q      <= a_next_d;
          b_out_q      <= b_next_d;
        end
        FEED: begin
          if (cnt_q == c_feed_last) begin
            state_q      <= DRAIN;
            cnt_q        <= '0;
            feed_valid_q <= 1'b0;
            a_out_q      <= '0;
            b_out_q      <= '0;
          end else begin
            cnt_q   <= cnt_q + c_cnt_w'(1);
            a_out_q <= a_next_d;
            b_out_q <= b_next_d;
          end
        end
        DRAIN: begin
          if (cnt_q == c_drain_last) begin
            state_q        <= DONE;
            cnt_q          <= '0;
            result_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + c_cnt_w'(1);
          end
        end
        DONE: begin
          state_q        <= IDLE;
          cnt_q          <= '0;
          result_valid_q <= 1'b0;
          busy_q         <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // The array also clears while the feeder itself is held in reset
  assign array_rst    = rst | (state_q == CLEAR);
  assign busy         = busy_q;
  assign feed_valid   = feed_valid_q;
  assign result_valid = result_valid_q;
  assign a_out        = a_out_q;
  assign b_out        = b_out_q;

endmodule
`default_nettype wire
